reg_scoreboard: RTL and testbench
=================================

// Module: reg_scoreboard
// PURPOSE
//  Register scoreboard and stall controller for the ID stage. Tracks in-flight writes per architectural
//  register, raises hazard_detected while an operand of the decoding instruction is still pending, and
//  retires entries on register-file writeback. Sits beside ID_Stage; drives its hazard_detected input.
// PARAMETERS
//  NUM_REGS   32  architectural registers; index width = $clog2(NUM_REGS)
//  CNT_W      2   per-register pending-counter width; max in-flight writes per reg = 2**CNT_W-1
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   asynchronous, active-low reset
//  id_valid        in   1   real instruction present in ID this cycle
//  id_src1         in   5   Instruction[25:21]
//  id_src2         in   5   Instruction[20:16]
//  id_single_src   in   1   1 = src2 not read (src2 check masked)
//  id_wb_en        in   1   decoding instruction writes a register (ungated control-unit WB_EN)
//  id_dest         in   5   destination of decoding instruction
//  wb_en           in   1   register-file write this cycle (WB_Write_Enable)
//  wb_dest         in   5   register-file write index (WB_Dest)
//  flush           in   1   synchronous clear of all pending state (pipeline flush)
//  hazard_detected out  1   stall ID/IF; bubble into EXE
//  pending         out  NUM_REGS  bit r = cnt[r]!=0 (registered view)
//  sb_err          out  1   sticky: retire to register with cnt==0
// BEHAVIOUR
//  - State: cnt[r] (CNT_W bits) for r=1..NUM_REGS-1; r=0 hardwired zero, never pending, never counted.
//  - Reset (rst=0, async): all cnt=0, pending=0, sb_err=0, hazard_detected=0.
//  - hazard_detected (combinational from registered cnt only) =
//    id_valid & ( (id_src1!=0 & cnt[id_src1]!=0)
//               | (!id_single_src & id_src2!=0 & cnt[id_src2]!=0)
//               | (id_wb_en & id_dest!=0 & cnt[id_dest]==MAX) )   // MAX = 2**CNT_W-1, WAW overflow stall
//  - Same-cycle retire does NOT clear a hazard; stall releases the cycle after the retiring writeback.
//  - issue  = id_valid & !hazard_detected & id_wb_en & id_dest!=0 -> cnt[id_dest]+1 at next edge.
//  - retire = wb_en & wb_dest!=0 -> cnt[wb_dest]-1 at next edge.
//  - issue & retire to same reg in one cycle: cnt unchanged. Different regs: both applied.
//  - retire with cnt==0: cnt stays 0 (no wrap), sb_err set to 1 until reset.
//  - Counter never exceeds MAX (guaranteed by overflow stall term); no wrap-around.
//  - flush=1: all cnt cleared at next edge; issue/retire that cycle ignored; sb_err unchanged;
//    hazard_detected still computed from current state in the flush cycle.
//  - pending/sb_err registered; update latency 1 cycle.
//  - Reset asserted mid-operation: all state cleared immediately, independent of clk.
// CONFIGURATION
//  SB_STALL_CNT_EN defined: adds output stall_cycles [31:0], counting cycles with hazard_detected=1;
//    reset 0, cleared by async reset only (not by flush), saturates at 32'hFFFF_FFFF.
//  SB_STALL_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 reset: rst=0 mid-run with cnt[5]=2 -> pending=0, hazard=0, sb_err=0 immediately.
//  2 RAW: issue dest=3; next cycle src1=3 -> hazard=1; wb_en,wb_dest=3 -> hazard=1 that cycle, 0 the next.
//  3 masking: src2=4 pending, single_src=1 -> hazard=0; src1=0 with id_valid=1 -> hazard=0; dest=0 never pending.
//  4 simultaneous: cnt[7]=1, issue dest=7 and retire 7 same cycle -> cnt[7]=1, pending[7]=1 unchanged.
//  5 overflow/underflow: 3 issues dest=9 (CNT_W=2) -> 4th with dest=9 stalls; retire to reg 12 with cnt 0
//    -> sb_err=1 sticky, pending[12]=0.
//  6 flush: cnt[2]=2, cnt[8]=1, flush=1 with issue dest=2 -> next cycle pending=0; with SB_STALL_CNT_EN,
//    stall_cycles equals number of hazard cycles driven and is not cleared by flush.

Source files
------------

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Register scoreboard and stall controller for the ID stage. Keeps a small
// pending-write counter per architectural register, stalls the decoding
// instruction while one of its operands is still in flight (or while its
// destination counter is full), and retires entries on register-file
// writeback.
//
// Ports
//   clk             in   rising-edge clock
//   rst             in   asynchronous active-low reset
//   id_valid        in   real instruction present in ID
//   id_src1         in   first source register index
//   id_src2         in   second source register index
//   id_single_src   in   1 = src2 is not read
//   id_wb_en        in   decoding instruction writes a register
//   id_dest         in   destination of the decoding instruction
//   wb_en           in   register-file write this cycle
//   wb_dest         in   register-file write index
//   flush           in   synchronous clear of all pending state
//   hazard_detected out  stall ID/IF, bubble into EXE
//   pending         out  bit r set while register r has writes in flight
//   sb_err          out  sticky: retire seen on a register with no pending write
//   stall_cycles    out  [31:0] saturating count of stall cycles
//                        (present only when SB_STALL_CNT_EN is defined)
//
// Configuration macro: SB_STALL_CNT_EN
// -----------------------------------------------------------------------------
module reg_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int CNT_W    = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        id_valid,
   input  logic [$clog2(NUM_REGS)-1:0] id_src1,
   input  logic [$clog2(NUM_REGS)-1:0] id_src2,
   input  logic                        id_single_src,
   input  logic                        id_wb_en,
   input  logic [$clog2(NUM_REGS)-1:0] id_dest,
   input  logic                        wb_en,
   input  logic [$clog2(NUM_REGS)-1:0] wb_dest,
   input  logic                        flush,
   output logic                        hazard_detected,
   output logic [NUM_REGS-1:0]         pending,
   output logic                        sb_err
`ifdef SB_STALL_CNT_EN
   ,
   output logic [31:0]                 stall_cycles
`endif
);

   localparam int               IDX_W   = $clog2(NUM_REGS);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0]    r_cnt     [NUM_REGS];
   logic [CNT_W-1:0]    w_cnt_nxt [NUM_REGS];
   logic [NUM_REGS-1:0] r_pending;
   logic [NUM_REGS-1:0] w_pend_nxt;
   logic                r_sb_err;

   logic                w_src1_busy;
   logic                w_src2_busy;
   logic                w_dest_full;
   logic                w_hazard;
   logic                w_issue;
   logic                w_retire;
   logic [NUM_REGS-1:0] w_inc_vec;
   logic [NUM_REGS-1:0] w_dec_vec;
   logic [NUM_REGS-1:0] w_undf_vec;
   logic                w_underflow;

   // Hazard terms look only at registered counters, so a writeback in the
   // same cycle does not release the stall until the following cycle.
   always_comb begin
      w_src1_busy = (id_src1 != '0) && (r_cnt[id_src1] != '0);
      w_src2_busy = !id_single_src && (id_src2 != '0) && (r_cnt[id_src2] != '0);
      // A full destination counter would wrap on another issue (WAW overflow).
      w_dest_full = id_wb_en && (id_dest != '0) && (r_cnt[id_dest] == CNT_MAX);
      w_hazard    = id_valid && (w_src1_busy || w_src2_busy || w_dest_full);
   end

   assign w_issue  = id_valid && !w_hazard && id_wb_en && (id_dest != '0);
   assign w_retire = wb_en && (wb_dest != '0);

   // One-hot decode of issue/retire targets. Register 0 is excluded by
   // w_issue/w_retire, so its counter can never leave zero.
   always_comb begin
      w_inc_vec = '0;
      w_dec_vec = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         w_inc_vec[r] = w_issue  && (id_dest == IDX_W'(r));
         w_dec_vec[r] = w_retire && (wb_dest == IDX_W'(r));
      end
   end

   always_comb begin
      w_pend_nxt = '0;
      w_undf_vec = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         w_cnt_nxt[r] = r_cnt[r];
         if (flush) begin
            // Flush wins over any issue/retire presented in the same cycle.
            w_cnt_nxt[r] = '0;
         end else begin
            w_undf_vec[r] = w_dec_vec[r] && (r_cnt[r] == '0);
            if (w_inc_vec[r] && !w_dec_vec[r]) begin
               w_cnt_nxt[r] = r_cnt[r] + CNT_W'(1);
            end else if (w_dec_vec[r] && !w_inc_vec[r] && (r_cnt[r] != '0)) begin
               w_cnt_nxt[r] = r_cnt[r] - CNT_W'(1);
            end
         end
         w_pend_nxt[r] = (w_cnt_nxt[r] != '0);
      end
   end

   assign w_underflow = |w_undf_vec;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            r_cnt[r] <= '0;
         end
         r_pending <= '0;
         r_sb_err  <= 1'b0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            r_cnt[r] <= w_cnt_nxt[r];
         end
         r_pending <= w_pend_nxt;
         r_sb_err  <= r_sb_err | w_underflow;
      end
   end

   assign hazard_detected = w_hazard;
   assign pending         = r_pending;
   assign sb_err          = r_sb_err;

`ifdef SB_STALL_CNT_EN
   logic [31:0] r_stall_cycles;

   // Performance counter: survives flush, saturates instead of wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cycles <= '0;
      end else if (w_hazard && (r_stall_cycles != 32'hFFFF_FFFF)) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        id_valid = 1'b0;
   logic [4:0]  id_src1 = '0;
   logic [4:0]  id_src2 = '0;
   logic        id_single_src = 1'b0;
   logic        id_wb_en = 1'b0;
   logic [4:0]  id_dest = '0;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_dest = '0;
   logic        flush = 1'b0;
   logic        hazard_detected;
   logic [31:0] pending;
   logic        sb_err;
`ifdef SB_STALL_CNT_EN
   logic [31:0] stall_cycles;
`endif

   reg_scoreboard #(.NUM_REGS(32), .CNT_W(2)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_valid        (id_valid),
      .id_src1         (id_src1),
      .id_src2         (id_src2),
      .id_single_src   (id_single_src),
      .id_wb_en        (id_wb_en),
      .id_dest         (id_dest),
      .wb_en           (wb_en),
      .wb_dest         (wb_dest),
      .flush           (flush),
      .hazard_detected (hazard_detected),
      .pending         (pending),
      .sb_err          (sb_err)
`ifdef SB_STALL_CNT_EN
      ,
      .stall_cycles    (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic        haz;
      logic [31:0] pend;
      logic        err;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   step_id  = 0;

   // Monitor: one expected record per cycle, compared away from the active edge.
   always @(negedge clk) begin
      if (q.size() != 0) begin
         mon_e = q.pop_front();
         n_checks++;
         if (hazard_detected !== mon_e.haz) begin
            n_fail++;
            $display("FAIL step%0d hazard: got %b expected %b", mon_e.id, hazard_detected, mon_e.haz);
         end
         n_checks++;
         if (pending !== mon_e.pend) begin
            n_fail++;
            $display("FAIL step%0d pending: got %h expected %h", mon_e.id, pending, mon_e.pend);
         end
         n_checks++;
         if (sb_err !== mon_e.err) begin
            n_fail++;
            $display("FAIL step%0d sb_err: got %b expected %b", mon_e.id, sb_err, mon_e.err);
         end
      end
   end

   task automatic push_exp(input logic eh, input logic [31:0] ep, input logic ee);
      exp_t e;
      e.id   = step_id;
      e.haz  = eh;
      e.pend = ep;
      e.err  = ee;
      q.push_back(e);
      step_id++;
   endtask

   // Apply one cycle of inputs and queue the expected outputs for that cycle.
   task automatic step(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                       input logic ss, input logic we, input logic [4:0] d,
                       input logic wb, input logic [4:0] wd, input logic fl,
                       input logic eh, input logic [31:0] ep, input logic ee);
      id_valid      = v;
      id_src1       = s1;
      id_src2       = s2;
      id_single_src = ss;
      id_wb_en      = we;
      id_dest       = d;
      wb_en         = wb;
      wb_dest       = wd;
      flush         = fl;
      push_exp(eh, ep, ee);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [31:0] ep, input logic ee);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ep, ee);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;

      // reset state
      idle(32'h0, 0);

      // RAW on r3: stall holds through the retiring cycle, releases after
      step(1, 0, 0, 1, 1, 3, 0, 0, 0, 0, 32'h0, 0);
      step(1, 3, 0, 1, 0, 0, 0, 0, 0, 1, 32'h8, 0);
      step(1, 3, 0, 1, 0, 0, 1, 3, 0, 1, 32'h8, 0);
      step(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0);

      // masking on r4
      step(1, 0, 0, 1, 1, 4, 0, 0, 0, 0, 32'h0, 0);
      step(1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 32'h10, 0);
      step(1, 0, 4, 0, 0, 0, 0, 0, 0, 1, 32'h10, 0);
      step(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 32'h10, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h10, 0);
      step(0, 4, 4, 0, 0, 0, 0, 0, 0, 0, 32'h10, 0);
      step(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 32'h10, 0);
      idle(32'h0, 0);

      // simultaneous issue+retire on r7 keeps count at 1
      step(1, 0, 0, 1, 1, 7, 0, 0, 0, 0, 32'h0, 0);
      step(1, 0, 0, 1, 1, 7, 1, 7, 0, 0, 32'h80, 0);
      idle(32'h80, 0);
      step(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 32'h80, 0);
      idle(32'h0, 0);

      // overflow on r9
      step(1, 0, 0, 1, 1, 9, 0, 0, 0, 0, 32'h0, 0);
      step(1, 0, 0, 1, 1, 9, 0, 0, 0, 0, 32'h200, 0);
      step(1, 0, 0, 1, 1, 9, 0, 0, 0, 0, 32'h200, 0);
      step(1, 0, 0, 1, 1, 9, 0, 0, 0, 1, 32'h200, 0);
      step(1, 0, 0, 1, 1, 9, 1, 9, 0, 1, 32'h200, 0);
      step(1, 0, 0, 1, 1, 9, 0, 0, 0, 0, 32'h200, 0);
      step(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 32'h200, 0);
      step(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 32'h200, 0);
      step(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 32'h200, 0);
      idle(32'h0, 0);

      // underflow on r12: sticky error
      step(0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 32'h0, 0);
      idle(32'h0, 1);
      idle(32'h0, 1);

      // flush with r2=2, r8=1
      step(1, 0, 0, 1, 1, 2, 0, 0, 0, 0, 32'h0, 1);
      step(1, 0, 0, 1, 1, 2, 0, 0, 0, 0, 32'h4, 1);
      step(1, 0, 0, 1, 1, 8, 0, 0, 0, 0, 32'h4, 1);
      step(1, 8, 0, 1, 0, 0, 0, 0, 0, 1, 32'h104, 1);
      step(1, 0, 0, 1, 1, 2, 1, 8, 1, 0, 32'h104, 1);
      idle(32'h0, 1);
      step(1, 2, 8, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1);

`ifdef SB_STALL_CNT_EN
      n_checks++;
      if (stall_cycles !== 32'd6) begin
         n_fail++;
         $display("FAIL stall_cycles: got %0d expected 6", stall_cycles);
      end
`endif

      // async reset mid-run with r5=2
      step(1, 0, 0, 1, 1, 5, 0, 0, 0, 0, 32'h0, 1);
      step(1, 0, 0, 1, 1, 5, 0, 0, 0, 0, 32'h20, 1);
      step(1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 32'h20, 1);
      id_valid      = 1'b1;
      id_src1       = 5'd5;
      id_single_src = 1'b1;
      id_wb_en      = 1'b0;
      rst           = 1'b0;
      push_exp(0, 32'h0, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle(32'h0, 0);
      step(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0);

`ifdef SB_STALL_CNT_EN
      n_checks++;
      if (stall_cycles !== 32'd0) begin
         n_fail++;
         $display("FAIL stall_cycles_after_reset: got %0d expected 0", stall_cycles);
      end
`endif

      for (int i = 0; i < 10 && q.size() != 0; i++) begin
         @(posedge clk);
      end
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending records expected 0", q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
